// File: rtl/mdu_pkg.sv
// Shared MDU definitions: multiply funct3 encodings and the control word that rides along the multiplier pipeline.
// Function-only package; no state, no latency.
package mdu_pkg;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;

    typedef struct packed {
        logic       valid;
        logic [2:0] funct3;
        logic       wordop;
    } mul_stage_t;

endpackage

// File: rtl/mul_csa_tree.sv
// Four-operand carry-save reduction built from a row of 4:2 compressors; purely combinational.
// Invariant: sum + carry == pp0 + pp1 + pp2 + pp3 modulo 2^WIDTH.
module mul_csa_tree #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] pp0,
    input  logic [WIDTH-1:0] pp1,
    input  logic [WIDTH-1:0] pp2,
    input  logic [WIDTH-1:0] pp3,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] cin;
    logic [WIDTH-2:0] cout;
    logic [WIDTH-2:0] cy;

    // First full-adder level; its carry feeds the neighbouring compressor, not the output.
    assign t    = pp0 ^ pp1 ^ pp2;
    assign cout = (pp0[WIDTH-2:0] & pp1[WIDTH-2:0]) |
                  (pp0[WIDTH-2:0] & pp2[WIDTH-2:0]) |
                  (pp1[WIDTH-2:0] & pp2[WIDTH-2:0]);
    assign cin  = {cout, 1'b0};

    assign sum  = t ^ pp3 ^ cin;
    assign cy   = (t[WIDTH-2:0] & pp3[WIDTH-2:0]) |
                  (t[WIDTH-2:0] & cin[WIDTH-2:0]) |
                  (pp3[WIDTH-2:0] & cin[WIDTH-2:0]);
    assign carry = {cy, 1'b0};

endmodule

// File: rtl/mul_pipe.sv
// Pipelined RV32/RV64 multiplier (MUL/MULH/MULHSU/MULHU/MULW); result STAGES unstalled cycles after accept.
// Stall freezes every register including valid bits; Flush clears all valid bits and wins over Stall.
module mul_pipe
    import mdu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InValid,
    input  logic [2:0]      Funct3,
    input  logic            WordOp,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Stall,
    input  logic            Flush,
    output logic            OutValid,
    output logic [XLEN-1:0] Result,
    output logic            Busy
);

    localparam int W = 2 * XLEN;
    localparam int H = XLEN - 1;

    logic         accept;
    logic         word_op;
    logic         sign_a;
    logic         sign_b;
    logic         msb_both;
    logic [H-1:0] a_lo;
    logic [H-1:0] b_lo;
    logic [H-1:0] row_a;
    logic [H-1:0] row_b;
    logic [W-3:0] core;
    logic [W-1:0] pp_core;
    logic [W-1:0] pp_rb;
    logic [W-1:0] pp_ra;
    logic [W-1:0] pp_fix;
    mul_stage_t   meta0;

    assign accept   = InValid & ~Funct3[2] & ~Stall;
    assign word_op  = (XLEN == 64) ? WordOp : 1'b0;
    // MULW only keeps low product bits, so it runs as an unsigned multiply.
    assign sign_a   = ~word_op & ((Funct3 == MULH_F3) | (Funct3 == MULHSU_F3));
    assign sign_b   = ~word_op & (Funct3 == MULH_F3);
    assign msb_both = SrcA[XLEN-1] & SrcB[XLEN-1];

    assign a_lo    = SrcA[H-1:0];
    assign b_lo    = SrcB[H-1:0];
    assign core    = {{H{1'b0}}, a_lo} * {{H{1'b0}}, b_lo};
    assign row_b   = ({H{SrcB[XLEN-1]}} & a_lo) ^ {H{sign_b}};
    assign row_a   = ({H{SrcA[XLEN-1]}} & b_lo) ^ {H{sign_a}};
    assign pp_core = {2'b00, core};
    assign pp_rb   = {2'b00, row_b, {H{1'b0}}};
    assign pp_ra   = {2'b00, row_a, {H{1'b0}}};

    // Correction constants fold the +1 of each inverted row and the sign weight of the MSB x MSB term.
    always_comb begin
        pp_fix = '0;
        if (sign_a && sign_b) begin
            pp_fix[W-1]  = 1'b1;
            pp_fix[W-2]  = msb_both;
            pp_fix[XLEN] = 1'b1;
        end else if (sign_a) begin
            pp_fix[W-1]    = 1'b1;
            pp_fix[W-2]    = ~msb_both;
            pp_fix[XLEN-1] = 1'b1;
        end else begin
            pp_fix[W-2] = msb_both;
        end
    end

    always_comb begin
        meta0        = '0;
        meta0.valid  = accept;
        meta0.funct3 = Funct3;
        meta0.wordop = word_op;
    end

    logic [3:0][W-1:0] s1_pp;
    mul_stage_t        s1_meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_pp   <= '0;
            s1_meta <= '0;
        end else begin
            if (!Stall) begin
                s1_pp   <= {pp_fix, pp_ra, pp_rb, pp_core};
                s1_meta <= meta0;
            end
            if (Flush) begin
                s1_meta.valid <= 1'b0;
            end
        end
    end

    logic [W-1:0] csa_sum;
    logic [W-1:0] csa_carry;

    mul_csa_tree #(.WIDTH(W)) u_csa (
        .pp0   (s1_pp[0]),
        .pp1   (s1_pp[1]),
        .pp2   (s1_pp[2]),
        .pp3   (s1_pp[3]),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    logic [W-1:0] red_sum;
    logic [W-1:0] red_carry;
    mul_stage_t   red_meta;

    if (STAGES >= 2) begin : g_csa_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                red_sum   <= '0;
                red_carry <= '0;
                red_meta  <= '0;
            end else begin
                if (!Stall) begin
                    red_sum   <= csa_sum;
                    red_carry <= csa_carry;
                    red_meta  <= s1_meta;
                end
                if (Flush) begin
                    red_meta.valid <= 1'b0;
                end
            end
        end
    end else begin : g_csa_comb
        assign red_sum   = csa_sum;
        assign red_carry = csa_carry;
        assign red_meta  = s1_meta;
    end

    logic [W-1:0] prod;
    logic [W-1:0] fin_prod;
    mul_stage_t   fin_meta;

    assign prod = red_sum + red_carry;

    if (STAGES == 3) begin : g_cpa_reg
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                fin_prod <= '0;
                fin_meta <= '0;
            end else begin
                if (!Stall) begin
                    fin_prod <= prod;
                    fin_meta <= red_meta;
                end
                if (Flush) begin
                    fin_meta.valid <= 1'b0;
                end
            end
        end
    end else begin : g_cpa_comb
        assign fin_prod = prod;
        assign fin_meta = red_meta;
    end

    logic [XLEN-1:0] word_res;

    if (XLEN == 64) begin : g_word64
        assign word_res = {{(XLEN-32){fin_prod[31]}}, fin_prod[31:0]};
    end else begin : g_word32
        assign word_res = fin_prod[XLEN-1:0];
    end

    always_comb begin
        Result = fin_prod[XLEN-1:0];
        if (fin_meta.wordop) begin
            Result = word_res;
        end else if (fin_meta.funct3 != MUL_F3) begin
            Result = fin_prod[W-1:XLEN];
        end
    end

    // With fewer stages the later aliases repeat s1/red valid bits, which leaves the OR unchanged.
    assign OutValid = fin_meta.valid;
    assign Busy     = s1_meta.valid | red_meta.valid | fin_meta.valid;

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, pipelined integer multiplier for the MDU. It executes RV32/RV64 MUL, MULH, MULHSU, MULHU and MULW.
- Configurable XLEN and register depth, with per-stage valid tracking, stall/flush control, and result selection and sign extension inside the block.
- Sits beside the divider. It takes forwarded operands in Execute and delivers an XLEN-bit result STAGES cycles later.

Parameters:
- XLEN, 64: operand and result width. Legal values are 32 and 64.
- STAGES, 2: register stages from operand capture to Result. Legal values are 1, 2 and 3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- InValid  in  1  operation request this cycle
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is not accepted
- WordOp  in  1  MULW. Legal only with Funct3=000 and XLEN=64.
- SrcA  in  XLEN  multiplicand
- SrcB  in  XLEN  multiplier
- Stall  in  1  freeze all pipeline registers
- Flush  in  1  kill all in-flight operations
- OutValid  out  1  Result holds a completed operation
- Result  out  XLEN  selected, sign-extended product
- Busy  out  1  any stage holds a valid operation

Behaviour:
- Reset: asynchronous, active-high.
  - All stage valid bits and all data registers go to 0.
  - Therefore OutValid=0, Result=0 and Busy=0 while reset is high and in the first cycle after release.
- Acceptance: an operation is accepted when InValid=1, Funct3[2]=0 and Stall=0. Requests with Funct3[2]=1 are ignored and no valid bit is set.
- Stage 0 (combinational, Execute):
  - Baugh-Wooley style partial products: unsigned (XLEN-1)x(XLEN-1) core product, two MSB-row vectors, and an MSB/correction-constant vector.
  - Row inversion and correction constants are chosen per Funct3 (signed x signed, signed x unsigned, unsigned x unsigned). MUL uses unsigned.
  - WordOp, Funct3 and the valid bit travel with the data.
- Register placement by STAGES:
  - STAGES=1: one register after the partial products. CSA reduction, CPA and result select are combinational after it.
  - STAGES=2: a second register after CSA reduction to sum/carry, which are 2*XLEN bits each.
  - STAGES=3: a third register after the CPA. Select is combinational.
- Latency: Result and OutValid appear exactly STAGES unstalled cycles after acceptance. Throughput is one operation per cycle.
- Result select:
  - MUL: Prod[XLEN-1:0].
  - MULH/MULHSU/MULHU: Prod[2XLEN-1:XLEN].
  - MULW: sign-extended Prod[31:0].
- WordOp handling:
  - When XLEN=32, WordOp is ignored.
  - When WordOp=1 with Funct3!=000, the block treats the operation as MULW. Decode guarantees this does not occur.
- Stall:
  - All registers, including valid bits, hold their values.
  - OutValid and Result stay constant for the whole stall.
  - No operation is duplicated or dropped.
- Flush: all valid bits clear on the next edge. Data registers are don't-care except under reset.
- Flush together with Stall: Flush wins and valid bits clear.
- Flush together with InValid: the new request is also discarded.
- Busy is the OR of all stage valid bits. It is combinational from registers only.
- No combinational path from the input ports to OutValid or Result.
- Arithmetic:
  - The final sum is the 2*XLEN-bit sum modulo 2^(2XLEN). Carry-out is discarded.
  - Operands are never widened beyond 2*XLEN.

Decomposition:
- Shared package mdu_pkg holds:
  - Funct3 localparams MUL_F3, MULH_F3, MULHSU_F3 and MULHU_F3.
  - A struct mul_stage_t {valid, funct3, wordop}.
- Sub-module mul_csa_tree (parameter WIDTH) reduces four WIDTH-bit partial products to sum/carry with 4:2 compressors. It is reused by STAGES=1 with the CPA appended combinationally.

Test Plan:
- XLEN=32, STAGES=1: MULH 0x80000000 x 0x80000000 -> Result 0x40000000 and OutValid=1, one cycle after acceptance.
- XLEN=32, STAGES=2:
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - MULHU same operands -> 0xFFFFFFFE.
  - MUL same operands -> 0x00000001.
  - Back-to-back issue gives each result on consecutive cycles.
- XLEN=64, STAGES=3: MULW (WordOp=1, Funct3=000) 0x7FFFFFFF x 0x2 -> 0xFFFFFFFFFFFFFFFE after 3 cycles.
- STAGES=2: issue A, B, C back-to-back and assert Stall for 3 cycles after B is accepted.
  - OutValid/Result for A is held constant through the stall.
  - Then B and C emerge in order with no repeats.
- Flush and Stall together with two operations in flight -> next cycle Busy=0. No OutValid appears for either operation.
- Assert reset with 3 operations in flight -> immediately OutValid=0, Result=0, Busy=0. After release, a MUL 3 x 5 -> 15 completes with normal latency.
